ds_es_pipe_reg: RTL

//  Decode->execute pipeline register; sits between the ID stage and ex, driving ex's ds_ex_reg_data bus.

---
 rtl/ds_es_pipe_reg_pkg.sv | 25 ++
 rtl/ds_es_pipe_reg_hazard_load_use.sv | 33 +++
 rtl/ds_es_pipe_reg.sv | 99 +++++++++
 3 files changed

// File: rtl/ds_es_pipe_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ds_es_pipe_reg_pkg
// Description : Decode->execute bundle width and field positions, shared by
//               decode, the ID/EX register and ex.
// Revision    : 1.0 - initial release
// ============================================================================
package ds_es_pipe_reg_pkg;

    // Width of the decode->execute bundle
    // {MemWrite,MemRead,RegWrite,MemtoReg[3:0],Mem_mode[2:0],Mem_read_us,
    //  OpControl[10:0],data1[31:0],data2[31:0],rd[4:0]}
    localparam int c_id_data         = 91;

    // Field positions inside the bundle
    localparam int c_id_rd_lsb       = 0;
    localparam int c_id_rd_w         = 5;
    localparam int c_id_memread_bit  = 89;
    localparam int c_id_memwrite_bit = 90;

    // Register index type
    typedef logic [c_id_rd_w-1:0] reg_idx_t;

endpackage : ds_es_pipe_reg_pkg
`default_nettype wire

// File: rtl/ds_es_pipe_reg_hazard_load_use.sv
`default_nettype none
// ============================================================================
// Module      : hazard_load_use
// Description : Combinational load-use compare between a held load and the
//               source registers of the instruction behind it.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_load_use
    import ds_es_pipe_reg_pkg::*;
(
    input  logic     held_valid,
    input  logic     held_memread,
    input  reg_idx_t held_rd,
    input  reg_idx_t src_rs1,
    input  reg_idx_t src_rs2,
    input  logic     src_rs1_used,
    input  logic     src_rs2_used,
    output logic     load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_rd_live;

    // x0 is hardwired zero, so a load into it can never create a dependency
    assign w_rd_live = (held_rd != '0);
    assign w_rs1_hit = src_rs1_used && (src_rs1 == held_rd);
    assign w_rs2_hit = src_rs2_used && (src_rs2 == held_rd);

    assign load_use  = held_valid && held_memread && w_rd_live && (w_rs1_hit || w_rs2_hit);

endmodule : hazard_load_use
`default_nettype wire

// File: rtl/ds_es_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : ds_es_pipe_reg
// Description : Decode->execute pipeline register with valid/allowin
//               handshake, load-use bubble insertion, flush and a saturating
//               bubble counter for debug.
// Revision    : 1.0 - initial release
// ============================================================================
module ds_es_pipe_reg
    import ds_es_pipe_reg_pkg::*;
#(
    parameter int DATA_W = c_id_data,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ds_to_es_valid,
    input  logic [DATA_W-1:0] ds_data,
    input  logic [4:0]        ds_rs1,
    input  logic [4:0]        ds_rs2,
    input  logic              ds_rs1_used,
    input  logic              ds_rs2_used,
    output logic              es_allowin,
    output logic              ds_stall,
    input  logic              ms_allowin,
    input  logic              flush,
    output logic              es_valid,
    output logic [DATA_W-1:0] ds_ex_reg_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_load_use;
    logic              w_accept;
    logic              w_bubble;
    reg_idx_t          w_es_rd;
    logic              w_es_memread;

    // Fields of the held instruction used by the hazard compare
    assign w_es_rd      = r_data[c_id_rd_lsb +: c_id_rd_w];
    assign w_es_memread = r_data[c_id_memread_bit];

    hazard_load_use u_hazard_load_use (
        .held_valid   (r_valid),
        .held_memread (w_es_memread),
        .held_rd      (w_es_rd),
        .src_rs1      (ds_rs1),
        .src_rs2      (ds_rs2),
        .src_rs1_used (ds_rs1_used),
        .src_rs2_used (ds_rs2_used),
        .load_use     (w_load_use)
    );

    // ex completes in one cycle, so space frees whenever MEM takes the held op
    assign es_allowin = !r_valid || ms_allowin;
    assign ds_stall   = w_load_use;
    assign w_accept   = ds_to_es_valid && es_allowin && !w_load_use && !flush;
    assign w_bubble   = ds_to_es_valid && es_allowin && w_load_use && !flush;

    // Valid bit: flush kills, otherwise advance on allowin, else hold
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (es_allowin) begin
            r_valid <= w_accept;
        end
    end

    // Payload only loads on accept; bubbles and flushes leave it untouched
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_data <= '0;
        end else if (w_accept) begin
            r_data <= ds_data;
        end
    end

    // Saturating count of inserted load-use bubbles
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stall_cnt <= '0;
        end else if (w_bubble && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign es_valid       = r_valid;
    assign ds_ex_reg_data = r_data;
    assign stall_cnt      = r_stall_cnt;

endmodule : ds_es_pipe_reg
`default_nettype wire
